// File: rtl/falu_issue_stage.sv
// Issue/result staging around the combinational FP ALU: an in-order op FIFO
// feeds the ALU operand ports and a valid/ready output register captures results.
module falu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_alu_op,
    input  logic [31:0]              in_op1,
    input  logic [31:0]              in_op2,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [3:0]               falu_alu_op,
    output logic [31:0]              falu_op1,
    output logic [31:0]              falu_op2,
    input  logic [31:0]              falu_result,
    input  logic                     falu_cmp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_cmp,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [3:0]       mem_op  [DEPTH];
    logic [31:0]      mem_op1 [DEPTH];
    logic [31:0]      mem_op2 [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             not_empty;
    logic             full;
    logic             push;
    logic             adv;

    assign not_empty = (occ != '0);
    assign full      = (occ == OCC_W'(DEPTH));
    assign in_ready  = ~full & ~flush;
    assign push      = in_valid & in_ready;
    assign adv       = not_empty & (~out_valid | out_ready) & ~flush;
    assign occupancy = occ;

    // ALU inputs depend only on stored state so the in_* path never reaches the ALU
    assign falu_alu_op = not_empty ? mem_op[rd_ptr]  : 4'h0;
    assign falu_op1    = not_empty ? mem_op1[rd_ptr] : 32'h0;
    assign falu_op2    = not_empty ? mem_op2[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]  <= in_alu_op;
            mem_op1[wr_ptr] <= in_op1;
            mem_op2[wr_ptr] <= in_op2;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (adv)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, adv})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cmp    <= 1'b0;
            out_tag    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid  <= 1'b1;
            out_result <= falu_result;
            out_cmp    <= falu_cmp;
            out_tag    <= mem_tag[rd_ptr];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_falu_issue_stage.sv
// Randomized bench for falu_issue_stage: a stub ALU drives the result ports and
// a queue-based reference model predicts every output cycle by cycle.
module tb_falu_issue_stage;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_alu_op;
    logic [31:0]       in_op1;
    logic [31:0]       in_op2;
    logic [TAG_W-1:0]  in_tag;
    logic [3:0]        falu_alu_op;
    logic [31:0]       falu_op1;
    logic [31:0]       falu_op2;
    logic [31:0]       falu_result;
    logic              falu_cmp;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic              out_cmp;
    logic [TAG_W-1:0]  out_tag;
    logic [$clog2(DEPTH):0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    falu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
        .falu_alu_op(falu_alu_op), .falu_op1(falu_op1), .falu_op2(falu_op2),
        .falu_result(falu_result), .falu_cmp(falu_cmp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cmp(out_cmp), .out_tag(out_tag),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Stand-in for the FP ALU: any deterministic function of the operands will do
    function automatic logic [32:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        r = (a + {b[15:0], b[31:16]}) ^ {8{op}};
        return {^(a ^ b), r};
    endfunction

    always_comb begin
        {falu_cmp, falu_result} = alu_fn(falu_alu_op, falu_op1, falu_op2);
    end

    typedef struct packed {
        logic [3:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } op_t;

    op_t              q[$];
    logic             m_ov;
    logic [31:0]      m_res;
    logic             m_cmp;
    logic [TAG_W-1:0] m_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ov  = 1'b0;
        m_res = '0;
        m_cmp = 1'b0;
        m_tag = '0;
    endtask

    task automatic step(input logic iv, input logic ordy, input logic fl);
        logic      exp_ready;
        logic      adv;
        logic [32:0] rc;
        op_t       cur;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_alu_op = 4'($urandom);
        in_op1    = $urandom;
        in_op2    = $urandom;
        in_tag    = TAG_W'($urandom);
        #1;
        exp_ready = (q.size() != DEPTH) && !fl;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            check("out_result", 64'(out_result), 64'(m_res));
            check("out_cmp", 64'(out_cmp), 64'(m_cmp));
            check("out_tag", 64'(out_tag), 64'(m_tag));
        end
        if (q.size() != 0) begin
            check("falu_drive", {28'h0, falu_alu_op, falu_op1}, {28'h0, q[0].op, q[0].a});
            check("falu_op2", 64'(falu_op2), 64'(q[0].b));
        end else begin
            check("falu_idle", {28'h0, falu_alu_op, falu_op1 | falu_op2}, 64'h0);
        end
        if (fl) begin
            q.delete();
            m_ov = 1'b0;
        end else begin
            adv = (q.size() != 0) && (!m_ov || ordy);
            if (adv) begin
                rc    = alu_fn(q[0].op, q[0].a, q[0].b);
                m_res = rc[31:0];
                m_cmp = rc[32];
                m_tag = q[0].tag;
                m_ov  = 1'b1;
                void'(q.pop_front());
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            if (iv && exp_ready) begin
                cur = '{op: in_alu_op, a: in_op1, b: in_op2, tag: in_tag};
                q.push_back(cur);
            end
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_occupancy", 64'(occupancy), 64'h0);
        check("rst_out_result", {31'h0, out_cmp, out_result}, 64'h0);
        model_clear();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_alu_op = '0; in_op1 = '0; in_op2 = '0; in_tag = '0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check("reset_out", {30'h0, out_valid, out_cmp, out_result}, 64'h0);
        check("reset_tag_occ", {out_tag, occupancy}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step(1'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 3; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4 * DEPTH + 4; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        mid_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 400; i++)
            step(1'($urandom), ($urandom % 4) != 0, ($urandom % 25) == 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        mid_reset();
        for (int i = 0; i < 200; i++)
            step(($urandom % 4) != 0, 1'($urandom), 1'b0);
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
